// File: rtl/rom_streamer_if.sv
// Bundle of the burst-control, ROM-read and output-stream signals of rom_streamer.
// Output stream: a word moves when out_valid & out_ready in the same cycle; out_valid/out_data hold until then.
interface rom_streamer_if #(
  parameter int asize = 11,
  parameter int width = 16
);
  logic             start;
  logic [asize-1:0] start_addr;
  logic [asize:0]   count;
  logic             busy;
  logic             done;
  logic             rom_en;
  logic [asize-1:0] rom_addr;
  logic [width-1:0] rom_dout;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic             out_last;
  logic [1:0]       dbg_state;

  modport slave (
    input  start, start_addr, count, rom_dout, out_ready,
    output busy, done, rom_en, rom_addr, out_valid, out_data, out_last, dbg_state
  );

  modport master (
    output start, start_addr, count, rom_dout, out_ready,
    input  busy, done, rom_en, rom_addr, out_valid, out_data, out_last, dbg_state
  );
endinterface

// File: rtl/rom_streamer.sv
// Streams a burst of words from a 1-cycle-latency ROM through a 2-entry output buffer.
// Reads are credit-limited so backpressure can never drop a returning word.
module rom_streamer #(
  parameter int size  = 2048,
  parameter int width = 16,
  parameter int asize = $clog2(size)
) (
  input logic         clk,
  input logic         rst,
  rom_streamer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [asize-1:0] addr_q, addr_d;
  logic [asize:0]   rd_left_q, rd_left_d;
  logic [asize:0]   out_left_q, out_left_d;
  logic             done_q, done_d;
  logic             infl_q;
  logic [width-1:0] buf_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       cnt_q;

  logic       out_valid, out_last, pop, push, rom_en;
  logic [2:0] occ;

  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & bus.out_ready;
  assign push      = infl_q;
  assign out_last  = out_valid && (out_left_q == (asize+1)'(1));
  // A word accepted this cycle frees its slot, which keeps one read per cycle.
  assign occ       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
  assign rom_en    = (state_q == RUN) && (rd_left_q != '0) && (occ < 3'd2);

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? buf_q[rd_ptr_q] : '0;
  assign bus.out_last  = out_last;
  assign bus.dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    if (pop) out_left_d = out_left_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            addr_d     = bus.start_addr;
            rd_left_d  = bus.count;
            out_left_d = bus.count;
          end
        end
      end
      RUN: begin
        if (rom_en) begin
          addr_d    = (addr_q == asize'(size - 1)) ? '0 : addr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
          if (rd_left_q == (asize+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      done_q     <= done_d;
    end
  end

  // rom_dout is only meaningful the cycle after a read was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      infl_q <= rom_en;
      if (push) begin
        buf_q[wr_ptr_q] <= bus.rom_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer: bench-side ROM model, stream monitor, one task per scenario.
module tb_rom_streamer;
  localparam int SIZE = 2048;
  localparam int W    = 16;
  localparam int AW   = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   s_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_streamer_if #(.asize(AW), .width(W)) bus ();
  rom_streamer #(.size(SIZE), .width(W), .asize(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [W-1:0] rom_word(input logic [AW-1:0] a);
    return W'(16'hA000 ^ {5'd0, a} ^ {a, 5'd0});
  endfunction

  always @(posedge clk) if (bus.rom_en) bus.rom_dout <= rom_word(bus.rom_addr);

  logic [AW-1:0] addr_log[$];
  int            addr_cyc[$];
  logic [W-1:0]  data_log[$];
  int            data_cyc[$];
  logic          last_log[$];
  logic [W-1:0]  exp_q[$];
  int done_cnt, done_cyc, busy_cnt, outst, max_outst, stall_err, busy_done_err;
  logic prev_stall;
  logic [W-1:0] prev_data;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      outst = 0;
    end else begin
      if (bus.rom_en) begin
        addr_log.push_back(bus.rom_addr);
        addr_cyc.push_back(cyc);
        outst++;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
      if (bus.out_valid && bus.out_ready) begin
        data_log.push_back(bus.out_data);
        data_cyc.push_back(cyc);
        last_log.push_back(bus.out_last);
        outst--;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        if (bus.busy) busy_done_err++;
      end
      if (bus.busy) busy_cnt++;
      if (outst > max_outst) max_outst = outst;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic clear_logs();
    addr_log.delete(); addr_cyc.delete(); data_log.delete(); data_cyc.delete();
    last_log.delete(); exp_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; outst = 0; max_outst = 0;
    stall_err = 0; busy_done_err = 0;
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input logic [AW:0] cnt, input bit bp,
                           input int inj_at, input logic [AW-1:0] inj_addr);
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = addr; bus.count = cnt; bus.out_ready = 1'b1;
    s_cyc = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.start = (i == inj_at);
      if (i == inj_at) bus.start_addr = inj_addr;
      bus.out_ready = bp ? pat[i % 4] : 1'b1;
      if (done_cnt > 0) break;
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL burst_timeout addr=%h count=%0d: no done seen", addr, cnt);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_en !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b rom_en=%b, required 0 0 0", bus.busy, bus.done, bus.rom_en);
    end
    checks++;
    if (bus.rom_addr !== '0 || bus.dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_addr rom_addr=%h state=%0d, required 0 0", bus.rom_addr, bus.dbg_state);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== '0) begin
      errors++; $display("FAIL reset_out valid=%b last=%b data=%h, required 0 0 0", bus.out_valid, bus.out_last, bus.out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(11'h010, 12'd4, 1'b0, -1, '0);
    for (int i = 0; i < 4; i++) exp_q.push_back(rom_word(AW'(11'h010 + i)));
    checks++;
    if (addr_log.size() != 4 || data_log.size() != 4) begin
      errors++; $display("FAIL basic_len reads=%0d words=%0d, required 4 4", addr_log.size(), data_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addr_log.size() || addr_log[i] !== AW'(11'h010 + i) || addr_cyc[i] != s_cyc + 1 + i) begin
        errors++; $display("FAIL basic_addr[%0d] got addr/cycle %h/%0d, required %h/%0d", i,
                           (i < addr_log.size()) ? addr_log[i] : 'x, (i < addr_cyc.size()) ? addr_cyc[i] - s_cyc : -1,
                           AW'(11'h010 + i), 1 + i);
      end
      checks++;
      if (i >= data_log.size() || data_log[i] !== exp_q[i] || data_cyc[i] != s_cyc + 3 + i || last_log[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_word[%0d] got data/cycle/last %h/%0d/%b, required %h/%0d/%b", i,
                           (i < data_log.size()) ? data_log[i] : 'x, (i < data_cyc.size()) ? data_cyc[i] - s_cyc : -1,
                           (i < last_log.size()) ? last_log[i] : 1'bx, exp_q[i], 3 + i, (i == 3));
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != s_cyc + 7 || busy_done_err != 0) begin
      errors++; $display("FAIL basic_done count=%0d cycle=%0d busy_with_done=%0d, required 1 7 0", done_cnt, done_cyc - s_cyc, busy_done_err);
    end
  endtask

  task automatic test_wrap();
    run_burst(11'h7FE, 12'd4, 1'b0, -1, '0);
    exp_q = '{rom_word(11'h7FE), rom_word(11'h7FF), rom_word(11'h000), rom_word(11'h001)};
    checks++;
    if (addr_log.size() != 4 || addr_log[0] !== 11'h7FE || addr_log[1] !== 11'h7FF || addr_log[2] !== 11'h000 || addr_log[3] !== 11'h001) begin
      errors++; $display("FAIL wrap_addr got %0d reads starting %h, required 7FE 7FF 000 001", addr_log.size(), addr_log.size() ? addr_log[0] : 'x);
    end
    checks++;
    if (data_log != exp_q) begin
      errors++; $display("FAIL wrap_data got %0d words first %h, required %0d words first %h", data_log.size(), data_log.size() ? data_log[0] : 'x, exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_backpressure();
    run_burst(11'h123, 12'd8, 1'b1, -1, '0);
    for (int i = 0; i < 8; i++) exp_q.push_back(rom_word(AW'(11'h123 + i)));
    checks++;
    if (data_log != exp_q) begin
      errors++; $display("FAIL bp_data got %0d words, required 8 in order from %h", data_log.size(), exp_q[0]);
    end
    checks++;
    if (stall_err != 0 || max_outst > 2) begin
      errors++; $display("FAIL bp_stall unstable_cycles=%0d max_outstanding=%0d, required 0 <=2", stall_err, max_outst);
    end
    checks++;
    if (last_log.size() != 8 || last_log[7] !== 1'b1 || last_log[0] !== 1'b0 || last_log[6] !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL bp_last words=%0d done=%0d, required last only on word 8 and one done", last_log.size(), done_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_burst(11'h055, 12'd0, 1'b0, -1, '0);
    checks++;
    if (addr_log.size() != 0 || busy_cnt != 0 || data_log.size() != 0) begin
      errors++; $display("FAIL zero_reads reads=%0d busy_cycles=%0d words=%0d, required 0 0 0", addr_log.size(), busy_cnt, data_log.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc != s_cyc + 1) begin
      errors++; $display("FAIL zero_done count=%0d cycle=%0d, required 1 1", done_cnt, done_cyc - s_cyc);
    end
  endtask

  task automatic test_start_busy();
    run_burst(11'h200, 12'd6, 1'b0, 2, 11'h400);
    for (int i = 0; i < 6; i++) exp_q.push_back(rom_word(AW'(11'h200 + i)));
    checks++;
    if (addr_log.size() != 6 || addr_log[5] !== 11'h205) begin
      errors++; $display("FAIL busy_start_addr reads=%0d last_addr=%h, required 6 205", addr_log.size(), addr_log.size() ? addr_log[addr_log.size()-1] : 'x);
    end
    checks++;
    if (data_log != exp_q || done_cnt != 1) begin
      errors++; $display("FAIL busy_start_data words=%0d done=%0d, required 6 words of first burst and 1 done", data_log.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = 11'h060; bus.count = 12'd2; bus.out_ready = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done_cycle done=%b busy=%b, required 1 0", bus.done, bus.busy);
    end
    bus.start = 1'b1; bus.start_addr = 11'h070;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (addr_log.size() != 4 || addr_log[0] !== 11'h060 || addr_log[1] !== 11'h061 || addr_log[2] !== 11'h070 || addr_log[3] !== 11'h071
        || addr_cyc[2] != s_cyc + 6 || addr_cyc[3] != s_cyc + 7) begin
      errors++; $display("FAIL b2b_addr reads=%0d third_cycle=%0d, required 060 061 070 071 with third at 6", addr_log.size(), addr_cyc.size() > 2 ? addr_cyc[2] - s_cyc : -1);
    end
    exp_q = '{rom_word(11'h060), rom_word(11'h061), rom_word(11'h070), rom_word(11'h071)};
    checks++;
    if (data_log != exp_q || done_cnt != 2) begin
      errors++; $display("FAIL b2b_data words=%0d done=%0d, required 4 2", data_log.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = 11'h300; bus.count = 12'd8; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 50 && data_log.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.rom_en !== 1'b0 || bus.rom_addr !== '0 || bus.out_valid !== 1'b0
        || bus.out_data !== '0 || bus.out_last !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_out busy=%b rom_en=%b addr=%h valid=%b data=%h last=%b, required all 0",
                         bus.busy, bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || data_log.size() != 3) begin
      errors++; $display("FAIL midrst_nodone done=%0d words=%0d, required 0 3", done_cnt, data_log.size());
    end
    run_burst(11'h050, 12'd5, 1'b0, -1, '0);
    for (int i = 0; i < 5; i++) exp_q.push_back(rom_word(AW'(11'h050 + i)));
    checks++;
    if (data_log != exp_q || done_cnt != 1) begin
      errors++; $display("FAIL midrst_after words=%0d done=%0d, required 5 words from 050 and 1 done", data_log.size(), done_cnt);
    end
  endtask

  task automatic test_full();
    int bad_addr, bad_data, bad_last;
    run_burst(11'h7F0, 12'd2048, 1'b0, -1, '0);
    bad_addr = 0; bad_data = 0; bad_last = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (i >= addr_log.size() || addr_log[i] !== AW'(11'h7F0 + i)) bad_addr++;
      if (i >= data_log.size() || data_log[i] !== rom_word(AW'(11'h7F0 + i))) bad_data++;
      if (i >= last_log.size() || last_log[i] !== (i == SIZE - 1)) bad_last++;
    end
    checks++;
    if (bad_addr != 0 || addr_log.size() != SIZE) begin
      errors++; $display("FAIL full_addr bad=%0d reads=%0d, required 0 %0d", bad_addr, addr_log.size(), SIZE);
    end
    checks++;
    if (bad_data != 0 || bad_last != 0 || data_log.size() != SIZE) begin
      errors++; $display("FAIL full_data bad_data=%0d bad_last=%0d words=%0d, required 0 0 %0d", bad_data, bad_last, data_log.size(), SIZE);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.start_addr = '0; bus.count = '0; bus.out_ready = 1'b1;
    clear_logs();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
